mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Parametrised multi-cycle MIPS main control FSM; successor to the fixed 5-state controller.
//  - Latches the opcode on a fetch handshake and classifies it.
//  - Sequences FETCH/DECODE/EXEC/MEM/WB with per-class early exit and memory wait-states.
//  - Drives datapath controls, raises illegal-opcode and memory-timeout flags.
//  Sits between the instruction fetch unit and the datapath (register file, ALU control, data memory, PC).
// PARAMETERS
//  OPW         6   opcode width
//  ALUOPW      6   alu_op width; must be >= OPW; opcode is zero-extended into it
//  SKIP_MEM    1   1: R/IMM/BR/J classes skip MEM; 0: legacy mode, every legal class visits MEM for 1 cycle
//  MEM_TIMEOUT 15  max cycles waiting for mem_ready in MEM; 0 disables the timeout
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  instr_valid  in   1       fetch unit presents a valid opcode
//  instr_ready  out  1       controller accepts an opcode (FETCH state only)
//  opcode       in   OPW     instr[31:26], sampled on valid&&ready
//  mem_ready    in   1       data memory completes the current read/write
//  reg_dst      out  2       00 rt, 01 rd, 10 $31 (jal)
//  alu_src      out  1       0 read-data2, 1 sign-extended immediate
//  alu_op       out  ALUOPW  0 for R-type, else zero-extended latched opcode
//  branch       out  1       conditional branch (beq/bne) enable for PC mux
//  jump         out  1       j/jal target select for PC mux
//  mem_read     out  1       load request, held until mem_ready or timeout
//  mem_write    out  1       store request, held until mem_ready or timeout
//  mem_to_reg   out  1       1 selects memory data for write-back
//  reg_write    out  1       register-file write enable, exactly 1 cycle per writing instruction
//  illegal_op   out  1       1-cycle pulse: undefined or coprocessor (0100xx) opcode
//  mem_timeout  out  1       1-cycle pulse: MEM wait exceeded MEM_TIMEOUT
//  state_o      out  3       current state, for debug
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FETCH, latched opcode=0, wait counter=0, all outputs 0 except instr_ready=1.
//  - Outputs are Moore: decoded from registered state + latched opcode only; all are 0 in FETCH except instr_ready.
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4; codes 5-7 go to FETCH next cycle, all outputs 0.
//  - FETCH: instr_ready=1; on instr_valid latch opcode and go to DECODE; otherwise stay.
//    instr_valid outside FETCH is ignored.
//  - DECODE: reg_dst set per class. Illegal opcode -> illegal_op=1 this cycle, next state FETCH, no write/mem.
//  - EXEC: alu_src, alu_op per class. Next state per class:
//    - BR: branch=1, done -> FETCH (or -> MEM when SKIP_MEM=0).
//    - J: jump=1, done -> FETCH (or -> MEM when SKIP_MEM=0). JAL: jump=1 and -> WB.
//    - R, IMM: -> WB (or -> MEM when SKIP_MEM=0).
//    - LD, ST: -> MEM.
//  - MEM:
//    - LD: mem_read=1, ST: mem_write=1.
//    - Stay in MEM until mem_ready; a cycle with mem_ready=1 is the last MEM cycle. Minimum 1 cycle.
//    - Wait counter is cleared on MEM entry and increments each MEM cycle without mem_ready.
//    - Counter reaching MEM_TIMEOUT without mem_ready: mem_timeout=1 that cycle, mem_read/mem_write=0 that cycle,
//      next state FETCH with no write-back.
//    - Exits: LD -> WB; ST -> FETCH. Legacy pass-through for BR/J/R/IMM ignores mem_ready: 1 cycle, then WB or FETCH.
//  - WB: reg_write=1 for R, IMM, LD, JAL. mem_to_reg=1 only for LD. Next state FETCH.
//  - Classes:
//    - R: 000000.
//    - J: 000010 j, 000011 jal.
//    - BR: 000100, 000101.
//    - IMM: 001000, 001010, 001100, 001101.
//    - LD: 100011.
//    - ST: 101011.
//    - Anything else is illegal.
//  - Cycles from handshake edge to return to FETCH (SKIP_MEM=1):
//    - BR/J: 3.
//    - R/IMM/JAL: 4.
//    - ST: 3+w, LD: 4+w, where w = MEM cycles (>=1).
//  - Reset asserted mid-instruction aborts immediately; no partial reg_write/mem_write survives the reset edge.
// STRUCTURE
//  - Shared package mc_ctrl_pkg holds:
//    - opcode localparams;
//    - state codes (3-bit);
//    - instruction class enum R/J/JAL/BR/IMM/LD/ST/ILL;
//    - reg_dst encodings.
//  - Sub-module mc_opcode_decode: combinational opcode -> class classifier, reused by the hazard unit.
// TESTING
//  1. rst_n low mid-EXEC of addi -> all outputs 0 immediately, state_o=0, instr_ready=1.
//  2. R-type 000000, SKIP_MEM=1 -> state_o 0,1,2,4,0. reg_dst=01, alu_op=0, reg_write=1 only in WB.
//  3. LW 100011, mem_ready low 3 cycles then high -> mem_read=1 for 4 cycles, then WB with reg_write=1, mem_to_reg=1.
//  4. SW 101011, mem_ready stuck low, MEM_TIMEOUT=15 -> mem_timeout pulse after 15 MEM cycles, no reg_write, back to FETCH.
//  5. beq 000100 -> branch=1 in EXEC only, FETCH 3 cycles after handshake. With SKIP_MEM=0: 4 cycles.
//  6. Opcodes 010001 and 111111 -> illegal_op pulse in DECODE, no mem/reg writes. jal 000011 -> reg_dst=10, jump=1, reg_write=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : mc_ctrl_pkg
// Brief   : Opcodes, state codes, instruction classes for the MIPS main control
// Rev     : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    localparam logic [1:0] c_regdst_rt = 2'b00;
    localparam logic [1:0] c_regdst_rd = 2'b01;
    localparam logic [1:0] c_regdst_ra = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CL_R, CL_J, CL_JAL, CL_BR, CL_IMM, CL_LD, CL_ST, CL_ILL
    } iclass_e;

    function automatic logic [1:0] regdst_of(input iclass_e cls);
        case (cls)
            CL_R:    return c_regdst_rd;
            CL_JAL:  return c_regdst_ra;
            default: return c_regdst_rt;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Interface : mc_control_fsm_if
// Brief     : Fetch handshake, memory ready and datapath controls of the FSM
// Rev       : 1.0  initial release
// ============================================================================
interface mc_control_fsm_if #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 6
);
    logic              instr_valid;
    logic              instr_ready;
    logic [OPW-1:0]    opcode;
    logic              mem_ready;
    logic [1:0]        reg_dst;
    logic              alu_src;
    logic [ALUOPW-1:0] alu_op;
    logic              branch;
    logic              jump;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              illegal_op;
    logic              mem_timeout;

    modport master (
        output instr_valid, opcode, mem_ready,
        input  instr_ready, reg_dst, alu_src, alu_op, branch, jump, mem_read,
               mem_write, mem_to_reg, reg_write, illegal_op, mem_timeout
    );

    modport slave (
        input  instr_valid, opcode, mem_ready,
        output instr_ready, reg_dst, alu_src, alu_op, branch, jump, mem_read,
               mem_write, mem_to_reg, reg_write, illegal_op, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/mc_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module : mc_opcode_decode
// Brief  : Combinational opcode -> instruction class classifier
// Rev    : 1.0  initial release
// ============================================================================
module mc_opcode_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] opcode_i,
    output iclass_e        class_o
);

    // Coprocessor opcodes (0100xx) fall through to the illegal class.
    always_comb begin
        class_o = CL_ILL;
        case (opcode_i)
            OPW'(c_op_rtype): class_o = CL_R;
            OPW'(c_op_j):     class_o = CL_J;
            OPW'(c_op_jal):   class_o = CL_JAL;
            OPW'(c_op_beq),
            OPW'(c_op_bne):   class_o = CL_BR;
            OPW'(c_op_addi),
            OPW'(c_op_slti),
            OPW'(c_op_andi),
            OPW'(c_op_ori):   class_o = CL_IMM;
            OPW'(c_op_lw):    class_o = CL_LD;
            OPW'(c_op_sw):    class_o = CL_ST;
            default:          class_o = CL_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module : mc_control_fsm
// Brief  : Multi-cycle MIPS main control FSM with memory wait-states/timeout
// Rev    : 1.0  initial release
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPW         = 6,
    parameter int ALUOPW      = 6,
    parameter int SKIP_MEM    = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_control_fsm_if.slave  bus,
    output logic [2:0]       state_o
);

    localparam int c_cnt_w  = $clog2(MEM_TIMEOUT + 2);
    localparam bit c_skip   = (SKIP_MEM != 0);
    localparam bit c_to_en  = (MEM_TIMEOUT != 0);

    if (ALUOPW < OPW) begin : g_bad_aluopw
        $error("mc_control_fsm: ALUOPW must be >= OPW");
    end

    state_e               state_q, state_d;
    logic [OPW-1:0]       op_q, op_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    iclass_e              w_cls;
    logic                 w_timeout;

    logic                 w_ready, w_alu_src, w_branch, w_jump, w_mem_read, w_mem_write;
    logic                 w_mem_to_reg, w_reg_write, w_illegal, w_mem_timeout;
    logic [1:0]           w_reg_dst;
    logic [ALUOPW-1:0]    w_alu_op;

    mc_opcode_decode #(.OPW(OPW)) u_decode (
        .opcode_i (op_q),
        .class_o  (w_cls)
    );

    // Registered count of MEM cycles spent without mem_ready; moore timeout.
    assign w_timeout = c_to_en && (w_cls == CL_LD || w_cls == CL_ST)
                       && (cnt_q == c_cnt_w'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = '0;
        w_ready       = 1'b0;
        w_reg_dst     = c_regdst_rt;
        w_alu_src     = 1'b0;
        w_alu_op      = '0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_reg_write   = 1'b0;
        w_illegal     = 1'b0;
        w_mem_timeout = 1'b0;
        case (state_q)
            ST_FETCH: begin
                w_ready = 1'b1;
                if (bus.instr_valid) begin
                    op_d    = bus.opcode;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_reg_dst = regdst_of(w_cls);
                if (w_cls == CL_ILL) begin
                    w_illegal = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_reg_dst = regdst_of(w_cls);
                w_alu_src = (w_cls == CL_IMM) || (w_cls == CL_LD) || (w_cls == CL_ST);
                w_alu_op  = (w_cls == CL_R) ? '0 : ALUOPW'(op_q);
                case (w_cls)
                    CL_BR: begin
                        w_branch = 1'b1;
                        state_d  = c_skip ? ST_FETCH : ST_MEM;
                    end
                    CL_J: begin
                        w_jump  = 1'b1;
                        state_d = c_skip ? ST_FETCH : ST_MEM;
                    end
                    CL_JAL: begin
                        w_jump  = 1'b1;
                        state_d = c_skip ? ST_WB : ST_MEM;
                    end
                    CL_R, CL_IMM: state_d = c_skip ? ST_WB : ST_MEM;
                    CL_LD, CL_ST: state_d = ST_MEM;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                w_reg_dst = regdst_of(w_cls);
                case (w_cls)
                    CL_LD, CL_ST: begin
                        if (w_timeout) begin
                            w_mem_timeout = 1'b1;
                            state_d       = ST_FETCH;
                        end else begin
                            w_mem_read  = (w_cls == CL_LD);
                            w_mem_write = (w_cls == CL_ST);
                            if (bus.mem_ready) begin
                                state_d = (w_cls == CL_LD) ? ST_WB : ST_FETCH;
                            end else begin
                                cnt_d = (cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
                            end
                        end
                    end
                    // Legacy pass-through: one cycle, mem_ready not consulted.
                    CL_R, CL_IMM, CL_JAL: state_d = ST_WB;
                    default:              state_d = ST_FETCH;
                endcase
            end
            ST_WB: begin
                w_reg_dst    = regdst_of(w_cls);
                w_reg_write  = (w_cls == CL_R) || (w_cls == CL_IMM)
                               || (w_cls == CL_LD) || (w_cls == CL_JAL);
                w_mem_to_reg = (w_cls == CL_LD);
                state_d      = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.instr_ready = w_ready;
    assign bus.reg_dst     = w_reg_dst;
    assign bus.alu_src     = w_alu_src;
    assign bus.alu_op      = w_alu_op;
    assign bus.branch      = w_branch;
    assign bus.jump        = w_jump;
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_write   = w_mem_write;
    assign bus.mem_to_reg  = w_mem_to_reg;
    assign bus.reg_write   = w_reg_write;
    assign bus.illegal_op  = w_illegal;
    assign bus.mem_timeout = w_mem_timeout;
    assign state_o         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_mc_control_fsm
// Brief  : Directed vector bench for mc_control_fsm (SKIP_MEM=1 and legacy)
// Rev    : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if #(.OPW(6), .ALUOPW(6)) bus0 ();
    mc_control_fsm_if #(.OPW(6), .ALUOPW(6)) bus1 ();
    logic [2:0] st0, st1;

    mc_control_fsm #(.OPW(6), .ALUOPW(6), .SKIP_MEM(1), .MEM_TIMEOUT(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .state_o(st0));
    mc_control_fsm #(.OPW(6), .ALUOPW(6), .SKIP_MEM(0), .MEM_TIMEOUT(15)) u_leg (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .state_o(st1));

    typedef struct packed {
        logic       rdy;
        logic [1:0] rd;
        logic       as;
        logic [5:0] aop;
        logic       br, j, mr, mw, m2r, rw, ill, to;
        logic [2:0] st;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        int         lat;
        int         cyc, rd, wr, rw, m2r, br, j, ill, to;
        logic [1:0] rdst;
        logic       asrc;
        logic [5:0] aop;
    } vec_t;

    typedef struct {
        int         cyc, rd, wr, rw, m2r, br, j, ill, to, bad;
        logic [1:0] rdst;
        logic       asrc;
        logic [5:0] aop;
    } res_t;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic obs_t sample(input bit leg);
        obs_t o;
        if (!leg) o = '{bus0.instr_ready, bus0.reg_dst, bus0.alu_src, bus0.alu_op, bus0.branch,
                        bus0.jump, bus0.mem_read, bus0.mem_write, bus0.mem_to_reg, bus0.reg_write,
                        bus0.illegal_op, bus0.mem_timeout, st0};
        else      o = '{bus1.instr_ready, bus1.reg_dst, bus1.alu_src, bus1.alu_op, bus1.branch,
                        bus1.jump, bus1.mem_read, bus1.mem_write, bus1.mem_to_reg, bus1.reg_write,
                        bus1.illegal_op, bus1.mem_timeout, st1};
        return o;
    endfunction

    function automatic logic [17:0] outs(input obs_t o);
        return {o.rdy, o.rd, o.as, o.aop, o.br, o.j, o.mr, o.mw, o.m2r, o.rw, o.ill, o.to};
    endfunction

    task automatic drive(input bit leg, input logic v, input logic [5:0] op, input logic mr);
        if (!leg) begin bus0.instr_valid = v; bus0.opcode = op; bus0.mem_ready = mr; end
        else      begin bus1.instr_valid = v; bus1.opcode = op; bus1.mem_ready = mr; end
    endtask

    // Issue one instruction; instr_valid stays high (with a different opcode)
    // until FETCH is seen again, so late valids must be ignored.
    task automatic run_instr(input bit leg, input logic [5:0] op, input int lat, output res_t r);
        obs_t o;
        int   memidx;
        bit   done;
        r = '{default: 0};
        memidx = 0;
        done   = 1'b0;
        @(negedge clk);
        o = sample(leg);
        check("idle_outputs", outs(o), 18'h20000);
        drive(leg, 1'b1, op, 1'b0);
        @(posedge clk);
        #1 drive(leg, 1'b1, ~op, 1'b0);
        for (int n = 1; n <= 40 && !done; n++) begin
            @(negedge clk);
            o = sample(leg);
            if (o.st == 3'd0) begin
                r.cyc = n;
                done  = 1'b1;
                drive(leg, 1'b0, 6'd0, 1'b0);
            end else begin
                r.rd  += int'(o.mr);  r.wr  += int'(o.mw);  r.rw += int'(o.rw);
                r.m2r += int'(o.m2r); r.br  += int'(o.br);  r.j  += int'(o.j);
                r.ill += int'(o.ill); r.to  += int'(o.to);
                if (o.rdy) r.bad++;
                if ((o.br || o.j) && o.st != 3'd2) r.bad++;
                if ((o.mr || o.mw || o.to) && o.st != 3'd3) r.bad++;
                if ((o.rw || o.m2r) && o.st != 3'd4) r.bad++;
                if (o.ill && o.st != 3'd1) r.bad++;
                if (o.st == 3'd1) r.rdst = o.rd;
                if (o.st == 3'd2) begin r.asrc = o.as; r.aop = o.aop; end
                if (o.st == 3'd3) begin
                    drive(leg, 1'b1, ~op, memidx >= lat);
                    memidx++;
                end else begin
                    drive(leg, 1'b1, ~op, 1'b0);
                end
            end
        end
        if (!done) begin
            r.cyc = -1;
            drive(leg, 1'b0, 6'd0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v[17];
        res_t        r;
        obs_t        o;
        logic [14:0] strace;
        logic [4:0]  rwtrace;

        //          op          lat cyc rd  wr rw m2r br j ill to rdst  as  aop
        v[0]  = '{6'b000000,  0,  4,  0,  0, 1, 0,  0, 0, 0, 0, 2'b01, 0,  0};
        v[1]  = '{6'b001000,  0,  4,  0,  0, 1, 0,  0, 0, 0, 0, 2'b00, 1,  8};
        v[2]  = '{6'b001010,  0,  4,  0,  0, 1, 0,  0, 0, 0, 0, 2'b00, 1, 10};
        v[3]  = '{6'b001100,  0,  4,  0,  0, 1, 0,  0, 0, 0, 0, 2'b00, 1, 12};
        v[4]  = '{6'b001101,  0,  4,  0,  0, 1, 0,  0, 0, 0, 0, 2'b00, 1, 13};
        v[5]  = '{6'b100011,  3,  8,  4,  0, 1, 1,  0, 0, 0, 0, 2'b00, 1, 35};
        v[6]  = '{6'b100011,  0,  5,  1,  0, 1, 1,  0, 0, 0, 0, 2'b00, 1, 35};
        v[7]  = '{6'b101011,  2,  6,  0,  3, 0, 0,  0, 0, 0, 0, 2'b00, 1, 43};
        v[8]  = '{6'b101011, 99, 19,  0, 15, 0, 0,  0, 0, 0, 1, 2'b00, 1, 43};
        v[9]  = '{6'b100011, 99, 19, 15,  0, 0, 0,  0, 0, 0, 1, 2'b00, 1, 35};
        v[10] = '{6'b000100,  0,  3,  0,  0, 0, 0,  1, 0, 0, 0, 2'b00, 0,  4};
        v[11] = '{6'b000101,  0,  3,  0,  0, 0, 0,  1, 0, 0, 0, 2'b00, 0,  5};
        v[12] = '{6'b000010,  0,  3,  0,  0, 0, 0,  0, 1, 0, 0, 2'b00, 0,  2};
        v[13] = '{6'b000011,  0,  4,  0,  0, 1, 0,  0, 1, 0, 0, 2'b10, 0,  3};
        v[14] = '{6'b010001,  0,  2,  0,  0, 0, 0,  0, 0, 1, 0, 2'b00, 0,  0};
        v[15] = '{6'b111111,  0,  2,  0,  0, 0, 0,  0, 0, 1, 0, 2'b00, 0,  0};
        v[16] = '{6'b100011, 14, 19, 15,  0, 1, 1,  0, 0, 0, 0, 2'b00, 1, 35};

        drive(1'b0, 1'b0, 6'd0, 1'b0);
        drive(1'b1, 1'b0, 6'd0, 1'b0);

        #12;
        o = sample(1'b0);
        check("reset_state", o.st, 0);
        check("reset_outputs", outs(o), 18'h20000);
        o = sample(1'b1);
        check("reset_outputs_legacy", outs(o), 18'h20000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_instr(1'b0, v[i].op, v[i].lat, r);
            check($sformatf("v%0d_cycles", i),     r.cyc,  v[i].cyc);
            check($sformatf("v%0d_mem_read", i),   r.rd,   v[i].rd);
            check($sformatf("v%0d_mem_write", i),  r.wr,   v[i].wr);
            check($sformatf("v%0d_reg_write", i),  r.rw,   v[i].rw);
            check($sformatf("v%0d_mem_to_reg", i), r.m2r,  v[i].m2r);
            check($sformatf("v%0d_branch", i),     r.br,   v[i].br);
            check($sformatf("v%0d_jump", i),       r.j,    v[i].j);
            check($sformatf("v%0d_illegal", i),    r.ill,  v[i].ill);
            check($sformatf("v%0d_timeout", i),    r.to,   v[i].to);
            check($sformatf("v%0d_reg_dst", i),    r.rdst, v[i].rdst);
            check($sformatf("v%0d_alu_src", i),    r.asrc, v[i].asrc);
            check($sformatf("v%0d_alu_op", i),     r.aop,  v[i].aop);
            check($sformatf("v%0d_misplaced", i),  r.bad,  0);
        end

        // R-type state trace and single-cycle reg_write.
        @(negedge clk);
        strace  = {12'd0, st0};
        rwtrace = {4'd0, bus0.reg_write};
        drive(1'b0, 1'b1, 6'b000000, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 6'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            strace  = {strace[11:0], st0};
            rwtrace = {rwtrace[3:0], bus0.reg_write};
        end
        check("rtype_state_trace", strace, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
        check("rtype_reg_write_trace", rwtrace, 5'b00010);

        // Asynchronous reset in the middle of an addi EXEC cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 6'b001000, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        o = sample(1'b0);
        check("addi_in_exec", o.st, 2);
        check("addi_exec_alu_src", o.as, 1);
        #2 rst_n = 1'b0;
        #1 o = sample(1'b0);
        check("midreset_state", o.st, 0);
        check("midreset_outputs", outs(o), 18'h20000);
        @(negedge clk);
        rst_n = 1'b1;

        // Legacy mode: every legal class visits MEM for one cycle.
        run_instr(1'b1, 6'b000100, 0, r);
        check("legacy_beq_cycles", r.cyc, 4);
        check("legacy_beq_branch", r.br, 1);
        check("legacy_beq_misplaced", r.bad, 0);
        run_instr(1'b1, 6'b000000, 0, r);
        check("legacy_r_cycles", r.cyc, 5);
        check("legacy_r_reg_write", r.rw, 1);
        run_instr(1'b1, 6'b101011, 1, r);
        check("legacy_sw_cycles", r.cyc, 5);
        check("legacy_sw_mem_write", r.wr, 2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
